// File: rtl/cpu_defs.sv
// cpu_defs: shared widths, opcode field, opcode constants and fetch state encoding
package cpu_defs;
  localparam int PC_W = 8;
  localparam int IR_W = 16;
  localparam int OP_HI = 15;
  localparam int OP_LO = 11;
  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_HALT = 5'b00001;
  localparam logic [4:0] OP_LOAD = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_BNZ = 5'b00101;
  localparam logic [4:0] OP_CMP = 5'b00110;
  localparam logic [IR_W-1:0] BUBBLE = '0;
  typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;
  function automatic logic [4:0] opcode(input logic [IR_W-1:0] ir);
    return ir[OP_HI:OP_LO];
  endfunction
endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, IF/ID register, run start, stall, branch flush and halt detection
module fetch_stage
  import cpu_defs::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IR_W-1:0] imem_data,
  output logic [IR_W-1:0] id_ir,
  output logic [PC_W-1:0] id_pc,
  output logic            halted,
  output logic [15:0]     issue_count
);
  fetch_state_t state, state_n;
  logic [PC_W-1:0] pc, pc_n, id_pc_n;
  logic [IR_W-1:0] id_ir_n;
  logic [15:0] count_n;
  logic is_halt;
  assign is_halt = opcode(imem_data) == OP_HALT;
  assign imem_addr = pc;
  assign halted = state == HALTED;
  always_comb begin
    state_n = state;
    pc_n = pc;
    id_ir_n = id_ir;
    id_pc_n = id_pc;
    count_n = issue_count;
    case (state)
      IDLE: begin
        id_ir_n = BUBBLE;
        state_n = enable ? RUN : IDLE;
      end
      RUN, HALTED: begin
        if (branch_taken) begin
          pc_n = branch_target;
          id_ir_n = BUBBLE;
          id_pc_n = '0;
          state_n = RUN;
        end else if (state == HALTED) begin
          id_ir_n = BUBBLE;
        end else if (!stall) begin
          id_ir_n = imem_data;
          id_pc_n = pc + 1'b1;
          pc_n = is_halt ? pc : pc + 1'b1;
          state_n = is_halt ? HALTED : RUN;
          count_n = (imem_data != BUBBLE && issue_count != 16'hFFFF) ? issue_count + 16'd1 : issue_count;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pc <= '0;
      id_ir <= BUBBLE;
      id_pc <= '0;
      issue_count <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      id_ir <= id_ir_n;
      id_pc <= id_pc_n;
      issue_count <= count_n;
    end
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit pipelined CPU. It owns the 8-bit program counter and drives the instruction memory's address port. It registers the asynchronously read instruction into the IF/ID pipeline register for the decode stage. It also handles run start, pipeline stall, branch redirect with flush, and halt detection.

## Interface
- PC_W, 8: program counter and instruction-memory address width.
- IR_W, 16: instruction width.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  start request, level-sampled in IDLE.
- stall  in  1  hold request from decode/hazard logic.
- branch_taken  in  1  redirect request from execute.
- branch_target  in  PC_W  redirect address.
- imem_addr  out  PC_W  address to instruction memory; equals pc.
- imem_data  in  IR_W  instruction memory read data, combinational from imem_addr.
- id_ir  out  IR_W  IF/ID instruction register.
- id_pc  out  PC_W  address of the id_ir instruction plus one.
- halted  out  1  high in HALTED state.
- issue_count  out  16  number of non-bubble instructions loaded into id_ir, saturating.

## Operation
- Opcode is ir[15:11]. NOP = 5'b00000 (bubble = 16'h0000). HALT = 5'b00001.
- States:
  - IDLE (reset state): id_ir <= bubble each cycle; pc holds; enable=1 -> RUN.
  - RUN: normal fetch.
  - HALTED: pc frozen; id_ir <= bubble; halted=1.
- RUN, per edge, in priority order:
  1. branch_taken: pc <= branch_target; id_ir <= bubble; id_pc <= 0. Overrides stall and HALT detection.
  2. stall: pc, id_ir, id_pc and issue_count hold.
  3. Fetched opcode == HALT: id_ir <= imem_data; id_pc <= pc+1; pc holds; -> HALTED.
  4. Otherwise: id_ir <= imem_data; id_pc <= pc+1; pc <= pc+1.
- PC arithmetic is mod 2^PC_W: 255 + 1 = 0, with no flag.
- HALTED exits only on reset or branch_taken. Branch_taken applies the branch rule (1) and moves to RUN, with halted=0 next cycle. This covers a branch resolved for an instruction older than HALT.
- issue_count increments on every edge that loads a non-bubble imem_data into id_ir. This includes the HALT instruction itself. It saturates at 16'hFFFF.
- IDLE leaves imem_addr stable at 0, so a loader may write the memory before enable.

## Timing
- Reset (async, immediate) values:
  - pc = 0, imem_addr = 0.
  - id_ir = 16'h0000, id_pc = 0.
  - halted = 0, issue_count = 0.
  - state = IDLE.
- enable sampled high at edge E: RUN from E. RAM[0] appears on id_ir after E+1, with id_pc = 1.
- Fetch latency: instruction at address A appears on id_ir one edge after pc == A. Throughput is one instruction per cycle.
- branch_taken at edge N: one bubble on id_ir after N; RAM[target] on id_ir after N+1.
- Stall applies to the same edge only; no lookahead.
- HALT at address H captured at edge N: halted=1 after N; id_ir = bubble after N+1; pc stays H.
- Reset mid-operation aborts instantly; no partial update completes.

## Structure
- Shared package cpu_defs holds:
  - PC_W and IR_W.
  - The opcode field position [15:11].
  - The opcode constants (NOP, HALT, LOAD, STORE, ADD, BNZ, CMP), used jointly with decode and i_memory contents.
  - The state encoding (IDLE, RUN, HALTED).
- Single flat module; no sub-module warranted.

## Test plan
- Reset, then hold enable=0 for 5 cycles -> imem_addr=0, id_ir=16'h0000, halted=0, issue_count=0 throughout.
- Memory with ADDs at 0..3; enable pulse -> id_ir sequence RAM[0..3] on consecutive cycles, id_pc = 1,2,3,4, issue_count = 4.
- Stall for 3 cycles while pc=2 -> pc, id_ir=RAM[1] and id_pc=2 frozen; resumes with RAM[2] on release.
- branch_taken with target 8'hBB, asserted together with stall -> next id_ir is bubble, then RAM[187]; pc = 188 after that.
- HALT at address 188 -> halted=1, pc stays 188, following id_ir bubbles. Then branch_taken with target 8'h05 -> RUN; id_ir becomes bubble then RAM[5].
- pc=255 holding ADD, no branch -> RAM[255] issued, then pc wraps to 0 and RAM[0] is fetched next; assert rst low mid-run -> all outputs return to reset values immediately.
